unified_mem_resp: RTL and testbench
===================================

Name: unified_mem_resp

Overview:
- Line-granular backing-memory responder that sits below the cache controller.
- Services one outstanding read or write of a full cache line, with a fixed, parameterised latency.
- Signals completion through a level `rdy`. It is the memory side of the cache-fill/write-back interface that drives the instruction and data ready stalls of the pipeline.
- Contains the memory array, request capture registers, a latency counter and a 3-state FSM.

Parameters:
- ADDR_W, 14, line-address width; array depth is 2^ADDR_W lines.
- LINE_W, 64, cache-line width in bits (four 16-bit words).
- LATENCY, 4, cycles a request is busy, legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  line address of request.
- re  in  1  read request.
- we  in  1  write request (write-back of a line).
- wr_data  in  LINE_W  line to write; sampled with the request.
- rd_data  out  LINE_W  line returned by the last completed read.
- rdy  out  1  high = idle/complete, request may be issued; low = busy.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rdy=1, rd_data=0, counter=0, captured addr/data/op cleared.
  - Array contents are not reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - rdy=1.
  - If re|we is high at a rising edge, capture addr, wr_data and op, load counter=LATENCY-1, go BUSY.
  - If neither is high, stay IDLE.
- re and we both high: treated as a write; no read data is produced and rd_data is unchanged.
- BUSY:
  - rdy=0.
  - Request inputs are ignored; changes to addr/wr_data/re/we have no effect.
  - Counter decrements each cycle. When counter==0: a write commits the captured line to array[captured addr]; a read loads rd_data<=array[captured addr]. Then go DONE.
- DONE:
  - rdy=1; rd_data holds the new line (read) or the previous value (write).
  - A request present in DONE is accepted exactly as in IDLE (go BUSY), which gives back-to-back operation. With no request, go IDLE.
- Latency: with a request sampled at edge N, rdy is low for cycles N+1..N+LATENCY and high again in cycle N+LATENCY+1 with valid rd_data. For LATENCY=1, rdy is low for exactly one cycle.
- rd_data stability: changes only on read completion or reset, and is held indefinitely otherwise.
- Read-after-write to the same line: the write commits before DONE, so a subsequent read returns the new data.
- Reset mid-BUSY: aborts immediately. A pending write is NOT committed, rdy returns to 1, rd_data=0.
- Address wrap: addr is exactly ADDR_W bits, so no out-of-range access is possible.
- A 1-cycle request pulse is sufficient; the requester need not hold re/we. A request held high through DONE is re-issued, and that is the requester's responsibility.
- Counter is 4 bits; no other arithmetic is performed.

Test Plan:
- Reset: hold rst_n=0 mid-simulation with re=1 -> rdy=1, rd_data=0, no transition. Release, then issue no request -> stays IDLE with rdy=1.
- Write then read (LATENCY=4):
  - we=1, addr=0x0010, wr_data=0x1111_2222_3333_4444 at edge N -> rdy=0 in cycles N+1..N+4, rdy=1 at N+5.
  - Then re=1, addr=0x0010 -> rd_data=0x1111_2222_3333_4444 exactly when rdy rises; held unchanged for 10 idle cycles.
- Back-to-back: read 0x0010 issued in the DONE cycle of the previous write -> accepted without an IDLE cycle; total 10 cycles edge-to-edge for two ops.
- Simultaneous re=we=1, addr=0x0020, wr_data=0xAAAA_BBBB_CCCC_DDDD -> treated as write; rd_data unchanged. A later read of 0x0020 returns 0xAAAA_BBBB_CCCC_DDDD.
- Input changes while BUSY: change addr to 0x0030 and toggle we during BUSY -> ignored; the original address is written/read and no second request is started.
- Reset mid-write: we to 0x0040 with data 0x5555_…, assert rst_n=0 two cycles later -> a subsequent read of 0x0040 returns the prior contents (written 0x0 beforehand), not 0x5555_….

Source files
------------

// File: rtl/unified_mem_resp.sv
// unified_mem_resp: line-granular backing memory with fixed-latency single-outstanding read/write and level rdy.
module unified_mem_resp #(
  parameter int ADDR_W  = 14,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [LINE_W-1:0] wr_data,
  output logic [LINE_W-1:0] rd_data,
  output logic              rdy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   cap_addr;
  logic [LINE_W-1:0]   cap_data;
  logic                cap_we;
  logic                done_now;
  logic [LINE_W-1:0]   mem [2**ADDR_W];
  assign done_now = state == BUSY && cnt == 4'd0;
  // rst_n gating keeps a write pending at reset from committing while reset is held
  always_ff @(posedge clk)
    if (rst_n && done_now && cap_we) mem[cap_addr] <= cap_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy      <= 1'b1;
      rd_data  <= '0;
      cnt      <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_we   <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (cnt == 4'd0) begin
            if (!cap_we) rd_data <= mem[cap_addr];
            state <= DONE;
            rdy   <= 1'b1;
          end else cnt <= cnt - 4'd1;
        end
        default: begin
          if (re | we) begin
            cap_addr <= addr;
            cap_data <= wr_data;
            cap_we   <= we;
            cnt      <= 4'(LATENCY - 1);
            state    <= BUSY;
            rdy      <= 1'b0;
          end else begin
            state <= IDLE;
            rdy   <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_resp.sv
// tb_unified_mem_resp: table vectors, corner sequences and random ops against a transaction-level memory model.
module tb_unified_mem_resp;
  localparam int AW = 14, LW = 64, LAT = 4;
  logic clk = 0, rst_n = 0, re = 0, we = 0, rdy;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wr_data = '0, rd_data;
  int checks = 0, fails = 0, edges = 0, acc_edge = 0, prev_edge = 0;
  logic [LW-1:0] model [logic [AW-1:0]];
  logic [LW-1:0] exp_rd = '0;
  typedef struct {logic r; logic w; logic [AW-1:0] a; logic [LW-1:0] d; logic [LW-1:0] exp;} vec_t;
  vec_t vt [6];

  unified_mem_resp #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
    .wr_data(wr_data), .rd_data(rd_data), .rdy(rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at the next rising edge, check busy window and completion.
  task automatic do_op(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [LW-1:0] d, input bit disturb);
    re = r; we = w; addr = a; wr_data = d;
    @(posedge clk);
    @(negedge clk);
    acc_edge = edges;
    re = 0; we = 0;
    if (w) model[a] = d;
    else if (r) exp_rd = model[a];
    for (int i = 0; i < LAT; i++) begin
      if (disturb) begin
        addr = AW'(16'h0030); we = ~we; re = 1'($urandom_range(0, 1));
        wr_data = {$urandom, $urandom};
      end
      check("busy_rdy", LW'(rdy), LW'(0));
      @(negedge clk);
    end
    re = 0; we = 0; addr = '0;
    check("done_rdy", LW'(rdy), LW'(1));
    check("done_rd_data", rd_data, exp_rd);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, AW'(16'h10), 64'h1111_2222_3333_4444, 64'h0};
    vt[1] = '{1'b1, 1'b0, AW'(16'h10), 64'h0, 64'h1111_2222_3333_4444};
    vt[2] = '{1'b1, 1'b1, AW'(16'h20), 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444};
    vt[3] = '{1'b1, 1'b0, AW'(16'h20), 64'h0, 64'hAAAA_BBBB_CCCC_DDDD};
    vt[4] = '{1'b0, 1'b1, AW'(16'h40), 64'h0, 64'hAAAA_BBBB_CCCC_DDDD};
    vt[5] = '{1'b1, 1'b0, AW'(16'h40), 64'h0, 64'h0};
    re = 1;
    repeat (3) begin
      @(negedge clk);
      check("reset_rdy", LW'(rdy), LW'(1));
      check("reset_rd_data", rd_data, '0);
    end
    re = 0; rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_rdy", LW'(rdy), LW'(1));
    end
    for (int i = 0; i < 6; i++) begin
      prev_edge = acc_edge;
      do_op(vt[i].r, vt[i].w, vt[i].a, vt[i].d, 1'b0);
      check("vec_rd_data", rd_data, vt[i].exp);
      if (i > 0) check("back_to_back", LW'(acc_edge - prev_edge), LW'(LAT + 1));
    end
    repeat (10) begin
      @(negedge clk);
      check("hold_rd_data", rd_data, exp_rd);
      check("hold_rdy", LW'(rdy), LW'(1));
    end
    do_op(1'b0, 1'b1, AW'(16'h50), 64'h0123_4567_89AB_CDEF, 1'b1);
    @(negedge clk);
    check("no_reissue", LW'(rdy), LW'(1));
    do_op(1'b1, 1'b0, AW'(16'h50), 64'h0, 1'b1);
    @(negedge clk);
    check("no_reissue_rd", LW'(rdy), LW'(1));
    we = 1; addr = AW'(16'h40); wr_data = 64'h5555_5555_5555_5555;
    @(posedge clk);
    @(negedge clk);
    we = 0;
    @(negedge clk);
    rst_n = 0; re = 1;
    #1;
    check("abort_rdy", LW'(rdy), LW'(1));
    check("abort_rd_data", rd_data, '0);
    repeat (2) @(negedge clk);
    check("abort_hold_rdy", LW'(rdy), LW'(1));
    re = 0; rst_n = 1; exp_rd = '0;
    @(negedge clk);
    check("post_reset_idle", LW'(rdy), LW'(1));
    do_op(1'b1, 1'b0, AW'(16'h40), 64'h0, 1'b0);
    check("abort_not_committed", rd_data, 64'h0);
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic r, w;
      a = AW'(16'h100 + $urandom_range(0, 7));
      r = model.exists(a) ? 1'($urandom_range(0, 1)) : 1'b0;
      w = !r || ($urandom_range(0, 3) == 0);
      do_op(r, w, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rand_idle_rdy", LW'(rdy), LW'(1));
        check("rand_idle_rd", rd_data, exp_rd);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
